// File: rtl/sev_seg_scan_if.sv
// Display-side bundle between the scanner and the rest of the system.
// The master side drives the load/value/digit_en inputs; the slave (the scanner) drives everything else.
interface sev_seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [3:0]              nibble;
    logic [NUM_DIGITS-1:0]   anode;
    logic                    blank;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_done;

    modport master (
        output load, value, digit_en,
        input  nibble, anode, blank, digit_idx, frame_done
    );

    modport slave (
        input  load, value, digit_en,
        output nibble, anode, blank, digit_idx, frame_done
    );
endinterface

// File: rtl/sev_seg_scan.sv
// Time-multiplexed common-anode seven-segment scanner with frame-aligned double buffering and dead-time.
// All outputs are registered from next-state values, so they describe the current slot cycle with no lag.
module sev_seg_scan #(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 100000,
    parameter int DEAD_CYCLES      = 16,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int LZ_BLANK         = 1
) (
    input logic          clk,
    input logic          rst,
    sev_seg_scan_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int W     = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      DEAD_END  = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};

    typedef enum logic {
        ST_DEAD,
        ST_ON
    } state_t;

    localparam state_t ST_SLOT_START = (DEAD_CYCLES != 0) ? ST_DEAD : ST_ON;

    state_t          state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [W-1:0]     shown, shown_nx, pending;
    logic             pend_vld;
    logic             frame_end;

    logic [NUM_DIGITS-1:0] sel_nx;
    logic [3:0]            nib_nx;
    logic                  upper_zero_nx;
    logic                  lit_nx;

    logic [3:0]            nibble_q;
    logic [NUM_DIGITS-1:0] anode_q;
    logic                  blank_q;
    logic                  frame_done_q;

    always_comb begin
        frame_end = (idx == IDX_LAST) && (cnt == CNT_LAST);

        cnt_nx = cnt + 1'b1;
        idx_nx = idx;
        if (cnt == CNT_LAST) begin
            cnt_nx = '0;
            idx_nx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end

        // A load on the frame's last cycle bypasses pending and goes straight to shown.
        shown_nx = shown;
        if (frame_end) begin
            if (bus.load)
                shown_nx = bus.value;
            else if (pend_vld)
                shown_nx = pending;
        end

        state_nx = state;
        if (cnt_nx == '0)
            state_nx = ST_SLOT_START;
        else if (cnt_nx == DEAD_END)
            state_nx = ST_ON;

        sel_nx        = '0;
        nib_nx        = '0;
        upper_zero_nx = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_nx[i] = (idx_nx == IDX_W'(i));
            if (sel_nx[i])
                nib_nx = shown_nx[4*i +: 4];
            if ((IDX_W'(i) >= idx_nx) && (shown_nx[4*i +: 4] != 4'h0))
                upper_zero_nx = 1'b0;
        end

        lit_nx = (state_nx == ST_ON)
              && (|(sel_nx & bus.digit_en))
              && !((LZ_BLANK != 0) && (idx_nx != '0) && upper_zero_nx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_SLOT_START;
            cnt          <= '0;
            idx          <= '0;
            shown        <= '0;
            pending      <= '0;
            pend_vld     <= 1'b0;
            nibble_q     <= '0;
            anode_q      <= ANODE_OFF;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            shown <= shown_nx;

            if (frame_end) begin
                pend_vld <= 1'b0;
            end else if (bus.load) begin
                pending  <= bus.value;
                pend_vld <= 1'b1;
            end

            nibble_q     <= nib_nx;
            anode_q      <= lit_nx ? (ANODE_OFF ^ sel_nx) : ANODE_OFF;
            blank_q      <= !lit_nx;
            frame_done_q <= (idx_nx == IDX_LAST) && (cnt_nx == CNT_LAST);
        end
    end

    assign bus.nibble     = nibble_q;
    assign bus.anode      = anode_q;
    assign bus.blank      = blank_q;
    assign bus.digit_idx  = idx;
    assign bus.frame_done = frame_done_q;
endmodule

// File: doc/sev_seg_scan.md
Name: sev_seg_scan

Overview:
- Time-multiplexed scanner for a common-anode multi-digit seven-segment display.
- Sits directly upstream of the per-digit seven-segment decoder:
  - Drives the decoder's 4-bit nibble input.
  - Drives the digit anode enables and a blank flag that downstream logic uses to gate segments.
- Double-buffers the displayed value so updates land only on frame boundaries (no tearing).
- Inserts dead-time between digits to suppress ghosting.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (≥1).
- REFRESH_DIV, 100000, clock cycles per digit slot (must be > DEAD_CYCLES).
- DEAD_CYCLES, 16, cycles at start of each slot with all anodes off (0 disables dead-time).
- ANODE_ACTIVE_LOW, 1, 1: anode bit low = digit on; 0: high = on.
- LZ_BLANK, 1, 1: enable leading-zero blanking.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- load  in  1  one-cycle strobe; captures value into pending buffer.
- value  in  4*NUM_DIGITS  hex digits, digit 0 = bits [3:0] (rightmost).
- digit_en  in  NUM_DIGITS  per-digit enable, sampled live each cycle.
- nibble  out  4  hex digit for current slot, to decoder input.
- anode  out  NUM_DIGITS  one-hot digit enable, polarity per ANODE_ACTIVE_LOW.
- blank  out  1  1 = current digit must show no segments.
- digit_idx  out  clog2(NUM_DIGITS) (min 1)  current slot index.
- frame_done  out  1  one-cycle pulse on the last cycle of the last slot.

Behaviour:
- Reset (asynchronous, immediate, no clock edge needed):
  - anode all inactive; nibble=0; blank=1; digit_idx=0; frame_done=0.
  - Slot counter=0; shown buffer=0; pending buffer=0; pending_valid=0.
- Slot counter cnt runs 0..REFRESH_DIV-1. On wrap, digit_idx increments, wrapping NUM_DIGITS-1 -> 0.
- Per-slot FSM:
  - DEAD: cnt < DEAD_CYCLES. Anodes inactive, blank=1.
  - ON: remaining cycles. If DEAD_CYCLES=0, DEAD is never entered.
- All outputs are registered and reflect the current cnt/digit_idx/state in the same cycle.
- nibble = shown[4*digit_idx +: 4] for the whole slot, including DEAD.
- In ON, anode[digit_idx] is active and all other anode bits are inactive, except:
  - digit_en[digit_idx]=0: anode stays inactive and blank=1 for the whole slot. The slot still consumes REFRESH_DIV cycles (constant frame period, uniform brightness).
  - LZ_BLANK=1 and digit_idx≠0 and shown digits NUM_DIGITS-1..digit_idx are all zero: anode inactive, blank=1. Digit 0 is never LZ-blanked.
- frame_done=1 exactly when digit_idx=NUM_DIGITS-1 and cnt=REFRESH_DIV-1.
- Buffering:
  - load writes value into pending and sets pending_valid.
  - Multiple loads within one frame: last one wins.
  - On the clock edge ending the frame_done cycle, if pending_valid: shown <= pending and pending_valid clears.
  - Load coincident with frame_done: that cycle's value is committed directly to shown at the same edge, and pending_valid is left clear.
- Changes to digit_en or value without load never corrupt the shown buffer.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles, always.

Test Plan:
1. NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2. Release reset.
   - Required: anode=4'b1111, blank=1 for cycles 0-1; anode=4'b1110, nibble=0, blank=0 for cycles 2-7.
   - Required: frame_done pulses at cycle 31 and every 32 cycles after.
2. Pulse load with value=16'h1234 at cycle 5.
   - Required: shown is unchanged until the frame_done edge (cycle 31).
   - Required: next frame slot0 nibble=4, anode=1110; slot3 nibble=1, anode=0111 during cnt 2-7.
3. Leading zeros, LZ_BLANK=1:
   - load 16'h0045 -> slots 2 and 3 have anode=1111, blank=1; slots 0 and 1 show 5 and 4.
   - load 16'h0000 -> only slot 0 lit, nibble=0.
4. Two loads in one frame (16'hAAAA, then 16'hBEEF), and separately a load exactly on the frame_done cycle.
   - Required: next frame shows BEEF.
   - Required: a coincident load is displayed from the very next frame.
5. digit_en=4'b0101.
   - Required: slots 1 and 3 dark (blank=1) for 8 cycles each; frame_done period stays 32 cycles.
6. Assert rst asynchronously mid-ON in slot 2.
   - Required: anode goes to 1111 and blank to 1 before the next clock edge; after release, scanning restarts at slot 0 with shown=0.
